// File: rtl/pulse_detector.sv
// Threshold/hysteresis pulse detector: measures peak, width and start timestamp of
// each qualified pulse and hands one event record at a time to a valid/ready consumer.
module pulse_detector #(
  parameter int ADC_WIDTH = 12,
  parameter int WIDTH_W   = 8,
  parameter int TS_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ADC_WIDTH-1:0] sample_in,
  input  logic                 sample_valid,
  input  logic [ADC_WIDTH-1:0] baseline,
  input  logic [ADC_WIDTH-1:0] threshold,
  input  logic [ADC_WIDTH-1:0] hysteresis,
  input  logic [WIDTH_W-1:0]   min_width,
  output logic                 event_valid,
  input  logic                 event_ready,
  output logic [ADC_WIDTH-1:0] event_peak,
  output logic [WIDTH_W-1:0]   event_width,
  output logic [TS_WIDTH-1:0]  event_ts,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic [CNT_WIDTH-1:0] glitch_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

  typedef enum logic {IDLE, PULSE} state_t;

  state_t               state_q, state_d;
  logic [ADC_WIDTH-1:0] peak_q, peak_d;
  logic [WIDTH_W-1:0]   width_q, width_d;
  logic [TS_WIDTH-1:0]  start_q, start_d;
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic                 ev_valid_q, ev_valid_d;
  logic [ADC_WIDTH-1:0] ev_peak_q, ev_peak_d;
  logic [WIDTH_W-1:0]   ev_width_q, ev_width_d;
  logic [TS_WIDTH-1:0]  ev_ts_q, ev_ts_d;
  logic [CNT_WIDTH-1:0] ev_cnt_q, ev_cnt_d;
  logic [CNT_WIDTH-1:0] gl_cnt_q, gl_cnt_d;
  logic [CNT_WIDTH-1:0] dr_cnt_q, dr_cnt_d;

  logic [ADC_WIDTH:0]   diff;
  logic [ADC_WIDTH-1:0] level;
  logic [ADC_WIDTH-1:0] release_lvl;
  logic                 emit;
  logic                 glitch;
  logic                 drain;

  always_comb begin
    diff        = {1'b0, sample_in} - {1'b0, baseline};
    level       = diff[ADC_WIDTH] ? '0 : diff[ADC_WIDTH-1:0];
    release_lvl = (hysteresis >= threshold) ? '0 : threshold - hysteresis;

    state_d = state_q;
    peak_d  = peak_q;
    width_d = width_q;
    start_d = start_q;
    ts_d    = sample_valid ? ts_q + TS_WIDTH'(1) : ts_q;
    emit    = 1'b0;
    glitch  = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else if (sample_valid) begin
      case (state_q)
        IDLE: begin
          if (level > threshold) begin
            state_d = PULSE;
            peak_d  = level;
            width_d = WIDTH_W'(1);
            start_d = ts_q;
          end
        end
        PULSE: begin
          if (level >= release_lvl) begin
            if (level > peak_q) peak_d = level;
            if (width_q != '1) width_d = width_q + WIDTH_W'(1);
          end else begin
            // Terminating sample: not part of the pulse and cannot re-trigger.
            state_d = IDLE;
            if (width_q >= min_width) emit = 1'b1;
            else                      glitch = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    drain      = ev_valid_q && event_ready;
    ev_valid_d = ev_valid_q;
    ev_peak_d  = ev_peak_q;
    ev_width_d = ev_width_q;
    ev_ts_d    = ev_ts_q;
    ev_cnt_d   = ev_cnt_q;
    gl_cnt_d   = gl_cnt_q;
    dr_cnt_d   = dr_cnt_q;

    if (emit) begin
      if (!ev_valid_q || drain) begin
        ev_valid_d = 1'b1;
        ev_peak_d  = peak_q;
        ev_width_d = width_q;
        ev_ts_d    = start_q;
        if (ev_cnt_q != '1) ev_cnt_d = ev_cnt_q + CNT_WIDTH'(1);
      end else if (dr_cnt_q != '1) begin
        dr_cnt_d = dr_cnt_q + CNT_WIDTH'(1);
      end
    end else if (drain) begin
      ev_valid_d = 1'b0;
    end

    if (glitch && gl_cnt_q != '1) gl_cnt_d = gl_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      peak_q     <= '0;
      width_q    <= '0;
      start_q    <= '0;
      ts_q       <= '0;
      ev_valid_q <= 1'b0;
      ev_peak_q  <= '0;
      ev_width_q <= '0;
      ev_ts_q    <= '0;
      ev_cnt_q   <= '0;
      gl_cnt_q   <= '0;
      dr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      peak_q     <= peak_d;
      width_q    <= width_d;
      start_q    <= start_d;
      ts_q       <= ts_d;
      ev_valid_q <= ev_valid_d;
      ev_peak_q  <= ev_peak_d;
      ev_width_q <= ev_width_d;
      ev_ts_q    <= ev_ts_d;
      ev_cnt_q   <= ev_cnt_d;
      gl_cnt_q   <= gl_cnt_d;
      dr_cnt_q   <= dr_cnt_d;
    end
  end

  assign event_valid  = ev_valid_q;
  assign event_peak   = ev_peak_q;
  assign event_width  = ev_width_q;
  assign event_ts     = ev_ts_q;
  assign event_count  = ev_cnt_q;
  assign glitch_count = gl_cnt_q;
  assign drop_count   = dr_cnt_q;

endmodule

// File: tb/tb_pulse_detector.sv
// Bench for pulse_detector: directed scenarios against hand-computed values plus
// randomized traffic against a pulse-list reference model.
module tb_pulse_detector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic [11:0] baseline, threshold, hysteresis;
  logic [7:0]  min_width;
  logic        event_valid, event_ready;
  logic [11:0] event_peak;
  logic [7:0]  event_width;
  logic [31:0] event_ts;
  logic [15:0] event_count, glitch_count, drop_count;

  int errors = 0;
  int checks = 0;

  pulse_detector dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .baseline(baseline), .threshold(threshold),
    .hysteresis(hysteresis), .min_width(min_width), .event_valid(event_valid),
    .event_ready(event_ready), .event_peak(event_peak), .event_width(event_width),
    .event_ts(event_ts), .event_count(event_count), .glitch_count(glitch_count),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference model: a pulse is the list of its sample levels; results derive from the list.
  bit          m_in_pulse;
  int          m_levels[$];
  int unsigned m_ts, m_start;
  bit          m_vld;
  int          m_peak, m_width, m_ec, m_gc, m_dc;
  int unsigned m_ets;

  task automatic model_reset();
    m_in_pulse = 0; m_levels.delete(); m_ts = 0; m_start = 0;
    m_vld = 0; m_peak = 0; m_width = 0; m_ets = 0; m_ec = 0; m_gc = 0; m_dc = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit rdy, input bit en);
    int lvl, rel, pk, w;
    bit drained, emit;
    drained = m_vld && rdy;
    emit = 0; pk = 0; w = 0;
    if (!en) begin
      m_in_pulse = 0; m_levels.delete();
    end else if (v) begin
      lvl = (s > int'(baseline)) ? s - int'(baseline) : 0;
      rel = (int'(threshold) > int'(hysteresis)) ? int'(threshold) - int'(hysteresis) : 0;
      if (!m_in_pulse) begin
        if (lvl > int'(threshold)) begin
          m_in_pulse = 1; m_levels.delete(); m_levels.push_back(lvl); m_start = m_ts;
        end
      end else if (lvl >= rel) begin
        m_levels.push_back(lvl);
      end else begin
        m_in_pulse = 0;
        foreach (m_levels[i]) if (m_levels[i] > pk) pk = m_levels[i];
        w = (m_levels.size() > 255) ? 255 : m_levels.size();
        if (w >= int'(min_width)) emit = 1;
        else if (m_gc < 65535) m_gc++;
        m_levels.delete();
      end
    end
    if (v) m_ts++;
    if (emit) begin
      if (!m_vld || drained) begin
        m_vld = 1; m_peak = pk; m_width = w; m_ets = m_start;
        if (m_ec < 65535) m_ec++;
      end else if (m_dc < 65535) m_dc++;
    end else if (drained) m_vld = 0;
  endtask

  // Called at a negedge; leaves the bench at the following negedge.
  task automatic step(input bit v, input int s, input bit rdy = 1'b1, input bit en = 1'b1);
    sample_valid = v; sample_in = s[11:0]; event_ready = rdy; enable = en;
    @(posedge clk);
    model_step(v, s, rdy, en);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = '0; event_ready = 1'b1;
    baseline = 12'd2048; threshold = 12'd200; hysteresis = 12'd50; min_width = 8'd3;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({event_valid, event_peak, event_width, event_ts, event_count, glitch_count, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%0b peak=%0d width=%0d ts=%0d ec=%0d gc=%0d dc=%0d, want all 0",
               event_valid, event_peak, event_width, event_ts, event_count, glitch_count, drop_count);
    end
    apply_reset();
  endtask

  task automatic test_basic();
    int smp[6] = '{2048, 2300, 2400, 2350, 2100, 2048};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, smp[i]);
      if (i < 4) begin
        checks++;
        if (event_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b at sample %0d, want 0", event_valid, i); end
      end
    end
    checks++;
    if (event_valid !== 1'b1 || event_peak !== 12'd352 || event_width !== 8'd3 || event_ts !== 32'd1 || event_count !== 16'd1) begin
      errors++;
      $display("FAIL basic_event: valid=%0b peak=%0d width=%0d ts=%0d ec=%0d, want 1/352/3/1/1",
               event_valid, event_peak, event_width, event_ts, event_count);
    end
    step(1'b1, smp[5]);
    checks++;
    if (event_valid !== 1'b0) begin errors++; $display("FAIL basic_clear: valid=%0b, want 0", event_valid); end
  endtask

  task automatic test_glitch();
    apply_reset();
    step(1'b1, 2300);
    step(1'b1, 2060);
    step(1'b0, 0);
    checks++;
    if (event_valid !== 1'b0 || glitch_count !== 16'd1 || event_count !== 16'd0) begin
      errors++;
      $display("FAIL glitch: valid=%0b gc=%0d ec=%0d, want 0/1/0", event_valid, glitch_count, event_count);
    end
  endtask

  task automatic test_hysteresis();
    apply_reset();
    step(1'b1, 2249);
    step(1'b1, 2220);
    step(1'b1, 2199);
    checks++;
    if (event_valid !== 1'b0) begin errors++; $display("FAIL hyst_held: valid=%0b, want 0", event_valid); end
    step(1'b1, 2197);
    checks++;
    if (event_valid !== 1'b1 || event_width !== 8'd3 || event_peak !== 12'd201 || event_ts !== 32'd0) begin
      errors++;
      $display("FAIL hyst_event: valid=%0b width=%0d peak=%0d ts=%0d, want 1/3/201/0",
               event_valid, event_width, event_peak, event_ts);
    end
  endtask

  task automatic test_back_to_back();
    int a[4] = '{2300, 2400, 2350, 2100};
    int b[4] = '{2300, 2500, 2300, 2100};
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, a[i], 1'b0);
    checks++;
    if (event_valid !== 1'b1 || event_peak !== 12'd352) begin
      errors++; $display("FAIL b2b_first: valid=%0b peak=%0d, want 1/352", event_valid, event_peak);
    end
    for (int i = 0; i < 4; i++) step(1'b1, b[i], 1'b0);
    checks++;
    if (event_valid !== 1'b1 || event_peak !== 12'd352 || event_width !== 8'd3 || event_ts !== 32'd0 ||
        drop_count !== 16'd1 || event_count !== 16'd1) begin
      errors++;
      $display("FAIL b2b_held: valid=%0b peak=%0d width=%0d ts=%0d dc=%0d ec=%0d, want 1/352/3/0/1/1",
               event_valid, event_peak, event_width, event_ts, drop_count, event_count);
    end
    step(1'b0, 0, 1'b1);
    checks++;
    if (event_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: valid=%0b, want 0", event_valid); end
  endtask

  task automatic test_enable_abort();
    int p[4] = '{2300, 2400, 2300, 2100};
    apply_reset();
    step(1'b1, 2048);
    repeat (4) step(1'b1, 2300);
    step(1'b1, 2300, 1'b1, 1'b0);
    step(1'b1, 2100);
    checks++;
    if (event_valid !== 1'b0 || event_count !== 16'd0 || glitch_count !== 16'd0 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL abort: valid=%0b ec=%0d gc=%0d dc=%0d, want 0/0/0/0", event_valid, event_count, glitch_count, drop_count);
    end
    for (int i = 0; i < 4; i++) step(1'b1, p[i]);
    checks++;
    if (event_valid !== 1'b1 || event_peak !== 12'd352 || event_width !== 8'd3 || event_ts !== 32'd7 || event_count !== 16'd1) begin
      errors++;
      $display("FAIL abort_recover: valid=%0b peak=%0d width=%0d ts=%0d ec=%0d, want 1/352/3/7/1",
               event_valid, event_peak, event_width, event_ts, event_count);
    end
  endtask

  task automatic test_width_saturation();
    apply_reset();
    step(1'b0, 4000);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 2400);
      if (i % 7 == 3) step(1'b0, 0);
    end
    step(1'b1, 2048);
    checks++;
    if (event_valid !== 1'b1 || event_width !== 8'd255 || event_ts !== 32'd0 || event_peak !== 12'd352) begin
      errors++;
      $display("FAIL width_sat: valid=%0b width=%0d ts=%0d peak=%0d, want 1/255/0/352",
               event_valid, event_width, event_ts, event_peak);
    end
  endtask

  task automatic test_mid_reset();
    int p[4] = '{2300, 2400, 2300, 2100};
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b1, p[i], 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (event_valid !== 1'b0 || event_count !== 16'd0 || event_ts !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%0b ec=%0d ts=%0d, want 0/0/0", event_valid, event_count, event_ts);
    end
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_random();
    int seg = 0;
    bit hi = 0;
    int s;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 500 == 0) begin
        step($urandom_range(0, 1) == 1, 2048, 1'b1, 1'b0);
        baseline   = 12'($urandom_range(1000, 3000));
        threshold  = 12'($urandom_range(20, 400));
        hysteresis = 12'($urandom_range(0, 450));
        min_width  = 8'($urandom_range(1, 5));
        step(1'b1, 0, 1'b1, 1'b0);
      end
      if (seg == 0) begin seg = $urandom_range(1, 10); hi = $urandom_range(0, 1) == 1; end
      seg--;
      s = hi ? int'(baseline) + $urandom_range(0, 600) - 50 : int'(baseline) + $urandom_range(0, 300) - 250;
      if (s < 0) s = 0;
      if (s > 4095) s = 4095;
      step($urandom_range(0, 3) != 0, s, $urandom_range(0, 3) != 0, $urandom_range(0, 60) != 0);
      checks++;
      if (event_valid !== m_vld) begin
        errors++; $display("FAIL rand_valid: cycle %0d got %0b want %0b", c, event_valid, m_vld);
      end
      if (m_vld) begin
        checks++;
        if (event_peak !== 12'(m_peak) || event_width !== 8'(m_width) || event_ts !== m_ets) begin
          errors++;
          $display("FAIL rand_payload: cycle %0d got peak=%0d width=%0d ts=%0d want %0d/%0d/%0d",
                   c, event_peak, event_width, event_ts, m_peak, m_width, m_ets);
        end
      end
      checks++;
      if (event_count !== 16'(m_ec) || glitch_count !== 16'(m_gc) || drop_count !== 16'(m_dc)) begin
        errors++;
        $display("FAIL rand_counters: cycle %0d got ec=%0d gc=%0d dc=%0d want %0d/%0d/%0d",
                 c, event_count, glitch_count, drop_count, m_ec, m_gc, m_dc);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample_in = '0; event_ready = 1'b1;
    baseline = 12'd2048; threshold = 12'd200; hysteresis = 12'd50; min_width = 8'd3;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_hysteresis();
    test_back_to_back();
    test_enable_abort();
    test_width_saturation();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
